// File: rtl/xadc_drp_sequencer_if.sv
// XADC-side signals of the DRP sequencer: end-of-conversion strobe plus the DRP read bus.
// master = sequencer, slave = XADC primitive (or its model).
interface xadc_drp_sequencer_if;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        den_out;
  logic        dwe_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic [15:0] do_in;
  logic        drdy_in;

  modport master (input eoc_in, channel_in, do_in, drdy_in,
                  output den_out, dwe_out, daddr_out, di_out);
  modport slave  (output eoc_in, channel_in, do_in, drdy_in,
                  input den_out, dwe_out, daddr_out, di_out);
endinterface

// File: rtl/xadc_drp_sequencer.sv
// Issues one DRP read per matched XADC end-of-conversion and stores the 12-bit result
// in one of four slots; one-deep pending buffer for overlapping conversions plus a drdy timeout.
module xadc_drp_sequencer #(
  parameter logic [6:0] SLOT0_ADDR = 7'h00,
  parameter logic [6:0] SLOT1_ADDR = 7'h16,
  parameter logic [6:0] SLOT2_ADDR = 7'h1E,
  parameter logic [6:0] SLOT3_ADDR = 7'h17,
  parameter int         TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  xadc_drp_sequencer_if.master        drp,
  input  logic [1:0]                  sel,
  output logic [11:0]                 sample_out,
  output logic                        sample_valid,
  output logic [1:0]                  sample_slot,
  output logic                        overrun,
  output logic                        timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef struct packed {
    logic       vld;
    logic [6:0] addr;
  } req_t;

  state_t            state, state_nxt;
  req_t              pend;
  logic [CW-1:0]     cnt;
  logic [1:0]        cur_slot;
  logic [3:0][11:0]  slots;
  logic [6:0]        eoc_addr, issue_addr;
  logic [2:0]        eoc_lk, issue_lk;
  logic              eoc_hit, cnt_last;

  // {hit, slot}; lowest slot index wins when parameters collide
  function automatic logic [2:0] lookup(input logic [6:0] a);
    if (a == SLOT0_ADDR)      return 3'b100;
    else if (a == SLOT1_ADDR) return 3'b101;
    else if (a == SLOT2_ADDR) return 3'b110;
    else if (a == SLOT3_ADDR) return 3'b111;
    else                      return 3'b000;
  endfunction

  assign eoc_addr   = {2'b00, drp.channel_in};
  assign eoc_lk     = lookup(eoc_addr);
  assign eoc_hit    = drp.eoc_in & eoc_lk[2];
  assign issue_addr = pend.vld ? pend.addr : eoc_addr;
  assign issue_lk   = lookup(issue_addr);
  // counter loads TIMEOUT and counts down once per WAIT cycle: TIMEOUT WAIT cycles in total
  assign cnt_last   = (cnt == CW'(1));
  assign sample_out = slots[sel];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pend.vld || eoc_hit) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (drp.drdy_in || cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    drp.den_out = (state == REQ);
    drp.dwe_out = 1'b0;
    drp.di_out  = '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend          <= '0;
      cnt           <= '0;
      cur_slot      <= '0;
      slots         <= '0;
      drp.daddr_out <= '0;
      sample_valid  <= 1'b0;
      sample_slot   <= '0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      // pending is consumed on issue from IDLE; a same-cycle eoc refills it without overrun
      if (state == IDLE) begin
        if (pend.vld) pend <= '{vld: eoc_hit, addr: eoc_addr};
      end else if (eoc_hit) begin
        pend <= '{vld: 1'b1, addr: eoc_addr};
        if (pend.vld) overrun <= 1'b1;
      end
      unique case (state)
        IDLE: if (pend.vld || eoc_hit) begin
          drp.daddr_out <= issue_addr;
          cur_slot      <= issue_lk[1:0];
        end
        REQ:  cnt <= CW'(TIMEOUT);
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (drp.drdy_in) begin
            slots[cur_slot] <= drp.do_in[15:4];
            sample_slot     <= cur_slot;
            sample_valid    <= 1'b1;
          end else if (cnt_last) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Scoreboarded bench: a DRP responder model plays out per-read plans, a monitor checks every
// sample_valid against expected {slot, value}; directed boundary cases then randomized traffic.
module tb_xadc_drp_sequencer;
  localparam int TO   = 64;
  localparam int NONE = -1;

  typedef struct {
    logic [6:0]  addr;
    int          dly;    // cycles from den to drdy; NONE = never answer
    logic [15:0] data;
    bit          ghost;  // answer, but the read is expected to be aborted by reset
  } plan_t;
  typedef struct {
    logic [1:0]  slot;
    logic [11:0] val;
  } samp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic [1:0]  sample_slot;
  logic        overrun, timeout_err;

  xadc_drp_sequencer_if drp();

  xadc_drp_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .drp(drp), .sel(sel), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_slot(sample_slot),
    .overrun(overrun), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  plan_t plans[$];
  samp_t samps[$];
  logic [11:0] model [4];
  logic [6:0]  slot_addr [4] = '{7'h00, 7'h16, 7'h1E, 7'h17};
  logic [6:0]  chans [8]     = '{7'h00, 7'h16, 7'h1E, 7'h17, 7'h03, 7'h01, 7'h10, 7'h1F};
  int den_cyc = 0, sv_cyc = 0, to_cyc = 0, eoc_cyc = 0, den_cnt = 0;
  bit exp_ovr = 0, exp_to = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int slot_of(input logic [6:0] a);
    for (int i = 0; i < 4; i++) if (slot_addr[i] == a) return i;
    return -1;
  endfunction

  task automatic add_plan(input logic [6:0] a, input int d, input logic [15:0] v, input bit g);
    plans.push_back('{addr: a, dly: d, data: v, ghost: g});
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic eoc(input logic [6:0] ch);
    drp.eoc_in = 1'b1; drp.channel_in = ch[4:0]; eoc_cyc = cyc;
    tick();
    drp.eoc_in = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_overrun"}, overrun, exp_ovr);
    chk({tag, "_timeout"}, timeout_err, exp_to);
  endtask

  // DRP responder: the XADC side of the handshake
  initial begin
    plan_t p;
    drp.drdy_in = 1'b0; drp.do_in = '0;
    forever begin
      @(negedge clk);
      if (rst_n && drp.den_out) begin
        den_cnt++; den_cyc = cyc;
        if (plans.size() == 0) chk("unexpected_den", 1, 0);
        else begin
          p = plans.pop_front();
          chk("den_daddr", drp.daddr_out, p.addr);
          if (p.dly >= 1) begin
            if (!p.ghost && p.dly <= TO)
              samps.push_back('{slot: 2'(slot_of(p.addr)), val: p.data[15:4]});
            repeat (p.dly) @(negedge clk);
            drp.drdy_in = 1'b1; drp.do_in = p.data;
            @(negedge clk);
            drp.drdy_in = 1'b0; drp.do_in = $urandom_range(0, 65535);
          end
        end
      end
    end
  end

  // Monitor: every sample_valid must match the next expected result
  initial begin
    samp_t s;
    bit to_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) model[i] = 12'h000;
        to_prev = 0;
      end else begin
        if (sample_valid) begin
          sv_cyc = cyc;
          if (samps.size() == 0) chk("unexpected_sample_valid", 1, 0);
          else begin
            s = samps.pop_front();
            model[s.slot] = s.val;
            chk("sample_slot", sample_slot, s.slot);
            chk("sample_out_on_valid", sample_out, model[sel]);
          end
        end
        if (timeout_err && !to_prev) to_cyc = cyc;
        to_prev = timeout_err;
      end
    end
  end

  initial begin
    logic [6:0]  first, ch;
    logic [6:0]  m[$];
    logic [6:0]  extra[$];
    int          r, d0;
    drp.eoc_in = 1'b0; drp.channel_in = '0;
    tick(3);
    chk("rst_den", drp.den_out, 0);
    chk("rst_dwe", drp.dwe_out, 0);
    chk("rst_di", drp.di_out, 0);
    chk("rst_daddr", drp.daddr_out, 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample_slot", sample_slot, 0);
    chk_flags("rst");
    rst_n = 1'b1;
    tick(2);

    // single read, drdy two cycles after den
    add_plan(7'h00, 2, 16'hA5C3, 0);
    eoc(7'h00);
    tick(10);
    chk("eoc_to_den", den_cyc - eoc_cyc, 1);
    chk("eoc_to_valid_d2", sv_cyc - eoc_cyc, 4);
    chk("slot0_A5C", sample_out, 12'hA5C);

    // minimum latency
    add_plan(7'h16, 1, 16'h1234, 0);
    eoc(7'h16);
    tick(10);
    chk("eoc_to_valid_min", sv_cyc - eoc_cyc, 3);

    // unmatched channel
    d0 = den_cnt;
    eoc(7'h03);
    tick(100);
    chk("unmatched_no_den", den_cnt, d0);
    chk_flags("unmatched");

    // overlap: 1E is overwritten in pending by 17
    add_plan(7'h16, 12, 16'hBEE0, 0);
    add_plan(7'h17, 3, 16'hCAF0, 0);
    eoc(7'h16); eoc(7'h1E); eoc(7'h17);
    exp_ovr = 1;
    tick(80);
    chk_flags("overlap");
    sel = 2'd2; #1;
    chk("overlap_slot2_untouched", sample_out, 12'h000);

    // timeout then recovery
    add_plan(7'h1E, NONE, 16'h0, 0);
    eoc(7'h1E);
    tick(80);
    exp_to = 1;
    chk("timeout_latency", to_cyc - den_cyc, TO + 1);
    chk_flags("timeout");
    chk("timeout_slot2_untouched", sample_out, 12'h000);
    add_plan(7'h1E, 3, 16'hFFF0, 0);
    eoc(7'h1E);
    tick(20);
    chk("slot2_FFF", sample_out, 12'hFFF);

    // drdy in last WAIT cycle is taken; one cycle later it is dropped
    add_plan(7'h00, TO, 16'h7770, 0);
    eoc(7'h00);
    tick(TO + 10);
    sel = 2'd0; #1;
    chk("drdy_last_wait", sample_out, 12'h777);
    add_plan(7'h17, TO + 1, 16'h5550, 0);
    eoc(7'h17);
    tick(TO + 10);
    sel = 2'd3; #1;
    chk("drdy_late_ignored", sample_out, 12'hCAF);

    // reset during WAIT; drdy after release must be ignored
    add_plan(7'h00, 3, 16'h9990, 1);
    eoc(7'h00);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_ovr = 0; exp_to = 0;
    tick(6);
    chk_flags("midreset");
    chk("midreset_den", drp.den_out, 0);
    chk("midreset_daddr", drp.daddr_out, 0);
    chk("midreset_slot", sample_slot, 0);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); #1;
      chk("midreset_slot_zero", sample_out, 12'h000);
    end

    // select sweep
    for (int i = 0; i < 4; i++) begin
      add_plan(slot_addr[i], 2, 16'(16'h1110 * (i + 1)), 0);
      eoc(slot_addr[i]);
      tick(8);
    end
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); #1;
      chk("sel_sweep", sample_out, 12'(12'h111 * (i + 1)));
    end

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        ch = chans[$urandom_range(0, 7)];
        if (slot_of(ch) >= 0) begin
          r = $urandom_range(0, 9);
          if (r < 7)       add_plan(ch, $urandom_range(1, 8), 16'($urandom), 0);
          else if (r == 7) add_plan(ch, TO, 16'($urandom), 0);
          else begin
            add_plan(ch, (r == 8) ? TO + 1 : NONE, 16'($urandom), 0);
            exp_to = 1;
          end
        end
        eoc(ch);
        tick(TO + 10);
      end else begin
        first = slot_addr[$urandom_range(0, 3)];
        m.delete(); extra.delete();
        for (int k = 0; k < $urandom_range(1, 3); k++) begin
          extra.push_back(chans[$urandom_range(0, 7)]);
          if (slot_of(extra[k]) >= 0) m.push_back(extra[k]);
        end
        add_plan(first, $urandom_range(10, 15), 16'($urandom), 0);
        if (m.size() > 0) add_plan(m[m.size()-1], $urandom_range(1, 6), 16'($urandom), 0);
        if (m.size() >= 2) exp_ovr = 1;
        eoc(first);
        foreach (extra[k]) eoc(extra[k]);
        tick(TO + 20);
      end
      sel = 2'($urandom_range(0, 3)); #1;
      chk("rand_sample_out", sample_out, model[sel]);
      chk_flags("rand");
    end

    tick(TO + 10);
    chk("plans_drained", plans.size(), 0);
    chk("samples_drained", samps.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xadc_drp_sequencer.md
# xadc_drp_sequencer

Controller that sequences Dynamic Reconfiguration Port (DRP) reads from the 7-series XADC primitive on the Basys3 sensor path. It is triggered by each end-of-conversion pulse and fetches the converted channel's result register. The 12-bit result is stored in one of four result slots, and one slot is presented to the downstream temperature-conversion and display logic under switch control. It owns the full den/drdy handshake, including overlap buffering and a timeout, so the conversion datapath only ever sees clean, stable 12-bit samples.

## Interface

Parameters:
- SLOT0_ADDR, 7'h00, DRP address stored in slot 0 (on-chip temperature)
- SLOT1_ADDR, 7'h16, DRP address stored in slot 1 (VAUX6)
- SLOT2_ADDR, 7'h1E, DRP address stored in slot 2 (VAUX14)
- SLOT3_ADDR, 7'h17, DRP address stored in slot 3 (VAUX7)
- TIMEOUT, 64, number of WAIT cycles without drdy before the read is abandoned (≥2)

Ports:
- clk  in  1  system clock; same clock as the XADC DCLK
- rst_n  in  1  asynchronous, active-low reset
- eoc_in  in  1  XADC end-of-conversion pulse, one cycle wide
- channel_in  in  5  XADC CHANNEL output, valid while eoc_in=1
- den_out  out  1  DRP enable, one-cycle pulse per read
- dwe_out  out  1  DRP write enable; constant 0
- daddr_out  out  7  DRP address; held from the den_out cycle until read completion
- di_out  out  16  DRP write data; constant 0
- do_in  in  16  DRP read data; bits [15:4] are the result, bits [3:0] are discarded
- drdy_in  in  1  DRP data-ready, one-cycle pulse
- sel  in  2  slot select, driven from {sw[1], sw[0]}
- sample_out  out  12  contents of the slot chosen by sel; combinational mux of registers
- sample_valid  out  1  one-cycle pulse when any slot is updated
- sample_slot  out  2  slot index of the last update; valid with sample_valid
- overrun  out  1  sticky flag: a pending request was overwritten
- timeout_err  out  1  sticky flag: a read exceeded TIMEOUT

## Operation

- Address match: daddr = {2'b00, channel_in}. A channel whose address matches no SLOTn_ADDR is ignored completely: no DRP access and no flag change. If two parameters are equal, the lowest slot index wins.
- States:
  - IDLE: no read in progress.
  - REQ: den_out=1 for exactly one cycle.
  - WAIT: den_out=0; a down-counter counts the timeout.
- IDLE → REQ on a matched eoc_in, or when the pending buffer is valid. Pending takes priority; a simultaneous new matched eoc is then written into pending.
- REQ → WAIT unconditionally. The timeout counter loads TIMEOUT.
- WAIT → IDLE on drdy_in=1. do_in[15:4] is written into the target slot, sample_slot is set, and sample_valid pulses.
- WAIT → IDLE when the counter reaches 0 with no drdy. The slot is unchanged, timeout_err is set, and no sample_valid is produced.
- A drdy_in arriving in IDLE or REQ is ignored.
- Pending buffer: one entry, holding a valid bit and a 7-bit address.
  - A matched eoc while in REQ or WAIT loads the buffer.
  - If the buffer is already valid, it is overwritten with the new address and overrun is set.
  - The buffer is consumed on the next IDLE → REQ transition.
- Flags and slots:
  - overrun and timeout_err clear only on reset.
  - Slots hold their value until their next successful read.
- Reset values (asynchronous):
  - state=IDLE
  - den_out=0
  - daddr_out=0
  - all slots=12'h000, so sample_out=12'h000
  - sample_valid=0
  - sample_slot=0
  - overrun=0
  - timeout_err=0
  - pending invalid
- Reset mid-read aborts the read immediately. A late drdy arriving after reset release lands in IDLE and is ignored.

## Timing

- Matched eoc_in sampled high at edge N (in IDLE): den_out=1 and daddr_out valid during cycle N+1, WAIT from N+2.
- drdy_in sampled high at edge M: slot register, sample_slot, and sample_valid are all updated at edge M. The new value appears on sample_out and sample_valid=1 during cycle M+1.
- Minimum eoc-to-sample_valid latency is 3 cycles (drdy returned the cycle after den).
- A pending request is issued with den_out during the cycle right after the WAIT → IDLE transition. There is one IDLE cycle between reads.
- Timeout: with no drdy, the state returns to IDLE TIMEOUT+1 cycles after the den cycle, and timeout_err is visible the same cycle.
- Changing sel changes sample_out combinationally within the same cycle.

## Test plan

- Reset then single read: eoc_in with channel_in=5'h00, drdy 2 cycles after den with do_in=16'hA5C3 → one den pulse with daddr=7'h00, slot0=12'hA5C, sample_valid pulse with sample_slot=0, and sel=0 shows 12'hA5C.
- Unmatched channel: eoc_in with channel_in=5'h03 → no den_out for 100 cycles, all outputs unchanged.
- Overlap and overrun: eocs for 7'h16, 7'h1E, and 7'h17 within 3 cycles, with drdy held off 10 cycles → first read 7'h16, overrun=1, second read 7'h17 (7'h1E dropped), two sample_valid pulses, slot2 still 12'h000.
- Timeout: TIMEOUT=64, eoc for 7'h1E, no drdy → timeout_err=1 exactly 65 cycles after den, slot2 unchanged. A following read with do_in=16'hFFF0 succeeds and gives slot2=12'hFFF.
- Reset mid-WAIT: assert rst_n=0 during WAIT, release, then pulse drdy_in → all outputs at reset values, no slot write, no sample_valid.
- Select sweep: load slots with 12'h111, 12'h222, 12'h333, 12'h444, step sel 0..3 → sample_out follows in the same cycle.
